regfile_access_ctrl: RTL and testbench

Controller in front of the 32x32 register file that owns its single write port (we3/wa3/wd3) and its debug read port.
- Shares the write port between core writeback and a debug host.
- Sequences a full register clear (x1..x31 to zero).
- Stalls the core whenever it takes the write port away from it.

---
 rtl/regfile_access_ctrl.sv | 126 ++++++++++++
 tb/tb_regfile_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file write-port arbiter: shares we3/wa3/wd3 between core writeback,
// a debug host and a self-timed x1..x31 clear, stalling the core when it loses the port.
module regfile_access_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_wa,
  input  logic [DATA_WIDTH-1:0] core_wd,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_in,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  rf_we3,
  output logic [ADDR_WIDTH-1:0] rf_wa3,
  output logic [DATA_WIDTH-1:0] rf_wd3,
  output logic [ADDR_WIDTH-1:0] rf_dbg_addr,
  input  logic [DATA_WIDTH-1:0] rf_dbg_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DBG, ACK} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [ADDR_WIDTH-1:0] r_dbg_addr;
  logic [DATA_WIDTH-1:0] r_dbg_wdata;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic                  r_dbg_we;
  logic                  r_clr_done;
  logic                  w_clr_last;
  logic                  w_starved;

  assign w_clr_last  = (r_clr_ptr == ADDR_WIDTH'(NUM_REGS - 1));
  assign w_starved   = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  assign clr_busy    = (r_state == CLEAR);
  assign dbg_gnt     = (r_state == ACK);
  assign clr_done    = r_clr_done;
  assign dbg_rdata   = r_dbg_rdata;
  assign rf_dbg_addr = r_dbg_addr;

  // Next state and write-port mux; the core owns the port unless overridden here
  always_comb begin
    w_state_nxt = r_state;
    rf_we3      = core_we;
    rf_wa3      = core_wa;
    rf_wd3      = core_wd;
    core_stall  = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_start)    w_state_nxt = CLEAR;
        else if (dbg_req) w_state_nxt = DBG;
      end
      CLEAR: begin
        rf_we3     = 1'b1;
        rf_wa3     = r_clr_ptr;
        rf_wd3     = '0;
        core_stall = 1'b1;
        if (w_clr_last) w_state_nxt = IDLE;
      end
      DBG: begin
        if (!r_dbg_we) begin
          w_state_nxt = ACK;
        end else if (!core_we || w_starved) begin
          // Either the port is free, or the core has had its quota of wins
          rf_we3      = 1'b1;
          rf_wa3      = r_dbg_addr;
          rf_wd3      = r_dbg_wdata;
          core_stall  = core_we;
          w_state_nxt = ACK;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_clr_ptr    <= '0;
      r_dbg_addr   <= '0;
      r_dbg_wdata  <= '0;
      r_dbg_rdata  <= '0;
      r_starve_cnt <= '0;
      r_dbg_we     <= 1'b0;
      r_clr_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_done <= (r_state == CLEAR) && w_clr_last;
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_clr_ptr <= ADDR_WIDTH'(1);
          end else if (dbg_req) begin
            r_dbg_we     <= dbg_we;
            r_dbg_addr   <= dbg_addr_in;
            r_dbg_wdata  <= dbg_wdata;
            r_starve_cnt <= '0;
          end
        end
        CLEAR: r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
        DBG: begin
          if (!r_dbg_we)                 r_dbg_rdata  <= rf_dbg_data;
          else if (core_we && !w_starved) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with a behavioural 32x32 register file attached.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_we;
  logic [4:0]  core_wa;
  logic [31:0] core_wd;
  logic        core_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr_in;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        rf_we3;
  logic [4:0]  rf_wa3;
  logic [31:0] rf_wd3;
  logic [4:0]  rf_dbg_addr;
  logic [31:0] rf_dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  regfile_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr_in(dbg_addr_in), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3),
    .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(rf_dbg_data)
  );

  always #5 clk = ~clk;

  // Register file: x0 reads zero and ignores writes; not affected by the controller reset
  logic [31:0] regs [32] = '{default: 32'h0};
  always @(posedge clk) if (rf_we3 && rf_wa3 != 5'd0) regs[rf_wa3] <= rf_wd3;
  assign rf_dbg_data = regs[rf_dbg_addr];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_stall;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [4:0] a, input logic [31:0] d);
    core_we = 1'b1; core_wa = a; core_wd = d;
    step();
    core_we = 1'b0;
  endtask

  task automatic dbg_read(input logic [4:0] a, input logic [31:0] exp, input string nm);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr_in = a;
    step();
    chk({nm, " rd addr"}, rf_dbg_addr, a);
    chk({nm, " rd gnt early"}, dbg_gnt, 1'b0);
    chk({nm, " rd stall"}, core_stall, 1'b0);
    step();
    chk({nm, " rd gnt"}, dbg_gnt, 1'b1);
    chk({nm, " rd data"}, dbg_rdata, exp);
    dbg_req = 1'b0;
    step();
    chk({nm, " rd gnt drop"}, dbg_gnt, 1'b0);
  endtask

  task automatic dbg_write_free(input logic [4:0] a, input logic [31:0] d, input string nm);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr_in = a; dbg_wdata = d;
    step();
    chk({nm, " wr we3"}, rf_we3, 1'b1);
    chk({nm, " wr wa3"}, rf_wa3, a);
    chk({nm, " wr wd3"}, rf_wd3, d);
    chk({nm, " wr stall"}, core_stall, 1'b0);
    chk({nm, " wr gnt early"}, dbg_gnt, 1'b0);
    step();
    chk({nm, " wr gnt"}, dbg_gnt, 1'b1);
    chk({nm, " wr ack we3"}, rf_we3, 1'b0);
    dbg_req = 1'b0;
    step();
    chk({nm, " wr gnt drop"}, dbg_gnt, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0] = '{1'b1, 5'd3,  32'h0000_0033, 1'b1, 5'd3,  32'h0000_0033, 1'b0};
    tbl[1] = '{1'b0, 5'd17, 32'hDEAD_BEEF, 1'b0, 5'd17, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{1'b1, 5'd0,  32'h1234_0000, 1'b1, 5'd0,  32'h1234_0000, 1'b0};
    tbl[4] = '{1'b1, 5'd12, 32'hA5A5_5A5A, 1'b1, 5'd12, 32'hA5A5_5A5A, 1'b0};

    reset_n = 1'b0;
    core_we = 1'b0; core_wa = '0; core_wd = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr_in = '0; dbg_wdata = '0;
    clr_start = 1'b0;

    // Reset state
    step(); step();
    chk("rst dbg_gnt", dbg_gnt, 1'b0);
    chk("rst dbg_rdata", dbg_rdata, 32'h0);
    chk("rst clr_busy", clr_busy, 1'b0);
    chk("rst clr_done", clr_done, 1'b0);
    chk("rst core_stall", core_stall, 1'b0);
    chk("rst rf_dbg_addr", rf_dbg_addr, 5'd0);
    reset_n = 1'b1;
    step();

    // IDLE pass-through of the core write port
    for (int i = 0; i < 5; i++) begin
      core_we = tbl[i].we; core_wa = tbl[i].wa; core_wd = tbl[i].wd;
      #1;
      chk($sformatf("mux%0d we3", i), rf_we3, tbl[i].e_we);
      chk($sformatf("mux%0d wa3", i), rf_wa3, tbl[i].e_wa);
      chk($sformatf("mux%0d wd3", i), rf_wd3, tbl[i].e_wd);
      chk($sformatf("mux%0d stall", i), core_stall, tbl[i].e_stall);
    end
    core_we = 1'b0;
    step();

    // 1: uncontended debug write, plus a write to x0
    dbg_write_free(5'd5, 32'h1234_5678, "t1");
    chk("t1 x5", regs[5], 32'h1234_5678);
    dbg_write_free(5'd0, 32'hDEAD_0000, "t1x0");
    chk("t1 x0", regs[0], 32'h0);

    // 2: debug read back
    dbg_read(5'd5, 32'h1234_5678, "t2");

    // 3: contended debug write, core writing x7 every cycle
    core_we = 1'b1; core_wa = 5'd7; core_wd = 32'h7000_00FF;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr_in = 5'd9; dbg_wdata = 32'hCAFE_BABE;
    step();
    for (int i = 0; i < 8; i++) begin
      core_wd = 32'h7000_0000 + i;
      #1;
      chk($sformatf("t3 pass%0d stall", i), core_stall, 1'b0);
      chk($sformatf("t3 pass%0d wa3", i), rf_wa3, 5'd7);
      chk($sformatf("t3 pass%0d gnt", i), dbg_gnt, 1'b0);
      step();
    end
    core_wd = 32'h7000_0008;
    #1;
    chk("t3 force stall", core_stall, 1'b1);
    chk("t3 force wa3", rf_wa3, 5'd9);
    chk("t3 force wd3", rf_wd3, 32'hCAFE_BABE);
    step();
    core_we = 1'b0;
    #1;
    chk("t3 gnt", dbg_gnt, 1'b1);
    chk("t3 ack stall", core_stall, 1'b0);
    dbg_req = 1'b0;
    step();
    chk("t3 x7", regs[7], 32'h7000_0007);
    chk("t3 x9", regs[9], 32'hCAFE_BABE);

    // 4: full clear with the core trying to write throughout
    core_write(5'd1, 32'hFFFF_FFFF);
    core_write(5'd15, 32'hFFFF_FFFF);
    core_write(5'd31, 32'hFFFF_FFFF);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    core_we = 1'b1; core_wa = 5'd15; core_wd = 32'h1515_1515;
    for (int i = 1; i <= 31; i++) begin
      #1;
      chk($sformatf("t4 c%0d busy", i), clr_busy, 1'b1);
      chk($sformatf("t4 c%0d stall", i), core_stall, 1'b1);
      chk($sformatf("t4 c%0d wa3", i), rf_wa3, i[4:0]);
      chk($sformatf("t4 c%0d wd3", i), rf_wd3, 32'h0);
      chk($sformatf("t4 c%0d done", i), clr_done, 1'b0);
      step();
    end
    core_we = 1'b0;
    #1;
    chk("t4 busy end", clr_busy, 1'b0);
    chk("t4 done", clr_done, 1'b1);
    step();
    chk("t4 done pulse", clr_done, 1'b0);
    dbg_read(5'd1, 32'h0, "t4x1");
    dbg_read(5'd15, 32'h0, "t4x15");
    dbg_read(5'd31, 32'h0, "t4x31");

    // 5: clear and debug read requested together; clear wins
    core_write(5'd3, 32'h0000_0033);
    clr_start = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr_in = 5'd3;
    step();
    clr_start = 1'b0;
    chk("t5 clear first", clr_busy, 1'b1);
    k = 0;
    while (!clr_done && k < 40) begin
      if (dbg_gnt) chk("t5 gnt during clear", dbg_gnt, 1'b0);
      step();
      k++;
    end
    chk("t5 clear cycles", k, 31);
    step();
    chk("t5 gnt +1", dbg_gnt, 1'b0);
    step();
    chk("t5 gnt +2", dbg_gnt, 1'b1);
    chk("t5 x3 rdata", dbg_rdata, 32'h0);
    dbg_req = 1'b0;
    step();

    // 6: reset in the middle of a clear
    core_write(5'd9, 32'h0000_0099);
    core_write(5'd10, 32'hAAAA_0010);
    core_write(5'd20, 32'hBBBB_0020);
    dbg_read(5'd20, 32'hBBBB_0020, "t6pre");
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (9) step();
    chk("t6 ptr10", rf_wa3, 5'd10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 rst busy", clr_busy, 1'b0);
    chk("t6 rst stall", core_stall, 1'b0);
    chk("t6 rst we3", rf_we3, 1'b0);
    chk("t6 rst rdata", dbg_rdata, 32'h0);
    chk("t6 rst dbg_addr", rf_dbg_addr, 5'd0);
    step();
    chk("t6 no done a", clr_done, 1'b0);
    step();
    chk("t6 no done b", clr_done, 1'b0);
    reset_n = 1'b1;
    step();
    chk("t6 idle done", clr_done, 1'b0);
    chk("t6 idle busy", clr_busy, 1'b0);
    chk("t6 x1", regs[1], 32'h0);
    chk("t6 x9", regs[9], 32'h0);
    chk("t6 x10", regs[10], 32'hAAAA_0010);
    chk("t6 x20", regs[20], 32'hBBBB_0020);
    dbg_read(5'd10, 32'hAAAA_0010, "t6x10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
